text_overlay_screen: RTL and testbench
======================================

// Module: text_overlay_screen
// PURPOSE
//  Parametrised full-screen text overlay (game-over / win / title screens) for the maze VGA path.
//  Reads glyph rows from an external synchronous font/text ROM and scales glyphs by 2^SCALE_LOG2.
//  Outputs a colour-cycling text bit into the RGB mux alongside the other screen generators.
//  Adds a show/hide FSM and a ROM-latency-matched pixel pipeline. The text window is placed by parameters.
// PARAMETERS
//  RGB_W      3           colour width of rgb_out
//  TICK_DIV   100000000   clk cycles per colour step (1 s at 100 MHz)
//  X0         0           window left edge, pixel units, inclusive
//  X1         639         window right edge, inclusive
//  Y0         128         window top edge, inclusive
//  Y1         383         window bottom edge, inclusive
//  SCALE_LOG2 2           glyph magnification = 2^SCALE_LOG2 (8x16 glyph -> 32x64 at 2)
//  ROM_LAT    1           ROM read latency in clk cycles (>=1)
// PORTS
//  clk       in   1      pixel/system clock
//  reset     in   1      synchronous, active-high reset
//  video_on  in   1      display-enable from VGA sync
//  pixel_x   in   10     current pixel column
//  pixel_y   in   10     current pixel row
//  start     in   1      1-cycle pulse: show overlay, restart colour sequence
//  clear     in   1      1-cycle pulse: hide overlay
//  freeze    in   1      level: hold colour counter and colour
//  rom_addr  out  11     {line[1:0], col[4:0], row[3:0]} to text ROM
//  rom_data  in   8      glyph row, MSB = leftmost pixel, valid ROM_LAT cycles after rom_addr
//  rgb_out   out  RGB_W  registered pixel colour
//  active    out  1      1 while FSM is in SHOW
// BEHAVIOUR
//  Reset (sync): state=HIDDEN, active=0, rgb_out=0, count=0, colour=1, pipeline flags=0.
//  Address generation (combinational): dx=pixel_x-X0 and dy=pixel_y-Y0, both 10 bit.
//   - col = dx>>(3+S) [4:0]; bit = (dx>>S)[2:0]; row = (dy>>S)[3:0]; line = (dy>>(4+S))[1:0].
//  in_win = X0<=pixel_x<=X1 && Y0<=pixel_y<=Y1. Outside the window rom_addr is don't-care.
//  Pipeline: {bit, in_win, video_on} delayed ROM_LAT stages so they align with rom_data.
//   - font_bit = rom_data[7-bit_d].
//  Output register: rgb_out <= (video_on_d && in_win_d && font_bit && vis && state==SHOW) ? colour : 0.
//   - Total pixel latency = ROM_LAT+1 clk. The sync path must delay hsync/vsync by the same amount.
//  FSM, 2 states:
//   - HIDDEN -> SHOW on start. Same edge: count<=0, colour<=1.
//   - SHOW -> HIDDEN on clear.
//   - SHOW + start: re-restarts the colour sequence and stays in SHOW.
//   - start && clear in the same cycle: clear wins (HIDDEN), colour not restarted.
//  Colour counter runs only in SHOW with freeze=0:
//   - count increments each clk.
//   - At count==TICK_DIV-1: count<=0 and colour steps.
//  Colour step: colour+1, skipping 0 (all-ones -> 1). Black is never an active text colour.
//  freeze=1 holds count and colour. Pixel output continues.
//  In HIDDEN, count and colour hold; rgb_out=0 from the cycle after the clear edge.
//  Reset mid-frame: output is 0 on the next clk. Pipeline contents are discarded.
//  vis=1 when the optional feature is compiled out.
// CONFIGURATION
//  TEXT_OVERLAY_BLINK_EN defined:
//   - blink phase bit; reset 1; set to 1 on start; toggles on every colour step.
//   - vis = phase: text is shown on alternate colour periods. freeze holds phase.
//  TEXT_OVERLAY_BLINK_EN undefined: no phase register; vis tied 1; text continuously visible in SHOW.
// TESTING
//  1 Reset: reset=1 two cycles, video_on=1 -> rgb_out=0, active=0, colour=1 after release.
//  2 Display: TICK_DIV=4, ROM_LAT=1, start pulse; ROM model with rom_data=8'h80 for addr 0.
//    - pixel (0,128): rgb_out=3'b001 two clk later.
//    - pixel (4,128): rgb_out=0 (bit 1 of 8'h80 is 0).
//  3 Colour wrap: TICK_DIV=4 in SHOW -> colour 1,2,...,7,1 every 4 clk; never 0.
//    - freeze=1 for 10 clk: colour unchanged.
//  4 Window: pixel_y=127 or 384, or video_on=0, with rom_data=8'hFF -> rgb_out=0.
//    - pixel (639,383) with rom_data=8'hFF -> rgb_out=colour.
//  5 FSM: start & clear same cycle -> active=0.
//    - clear in SHOW -> active=0 next clk, rgb_out=0.
//    - start while colour=5 -> colour=1, count=0.
//  6 TEXT_OVERLAY_BLINK_EN, TICK_DIV=4: text lit clk 0-3, dark 4-7, lit 8-11 after start.
//    - Macro undefined: lit throughout.

Source files
------------

// File: rtl/text_overlay_screen.sv
// text_overlay_screen: full-screen text overlay with a show/hide FSM.
// Glyph rows come from an external synchronous text ROM. Glyphs are magnified
// by 2^SCALE_LOG2. Text is drawn in a colour that steps every TICK_DIV clocks.
// The pixel pipeline is matched to the ROM latency, so the total pixel latency
// is ROM_LAT+1 clocks.
// Optional feature: define TEXT_OVERLAY_BLINK_EN to blink the text on
// alternate colour periods.
module text_overlay_screen #(
    parameter int RGB_W      = 3,
    parameter int TICK_DIV   = 100000000,
    parameter int X0         = 0,
    parameter int X1         = 639,
    parameter int Y0         = 128,
    parameter int Y1         = 383,
    parameter int SCALE_LOG2 = 2,
    parameter int ROM_LAT    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             video_on,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic             start,
    input  logic             clear,
    input  logic             freeze,
    output logic [10:0]      rom_addr,
    input  logic [7:0]       rom_data,
    output logic [RGB_W-1:0] rgb_out,
    output logic             active
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic {
        HIDDEN = 1'b0,
        SHOW   = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [RGB_W-1:0]         colour_q, colour_d;
    logic [RGB_W-1:0]         colour_step;
    logic [RGB_W-1:0]         rgb_q, rgb_d;
    logic                     vis;

    // Window-relative coordinates. Pixels left of / above the window wrap to
    // large unsigned values, so a single upper-bound compare covers both edges.
    logic [9:0]               dx, dy;
    logic [2:0]               bit_sel;
    logic                     in_win;

    // Flags delayed to line up with rom_data.
    logic [ROM_LAT-1:0][2:0]  bit_pipe_q, bit_pipe_d;
    logic [ROM_LAT-1:0]       win_pipe_q, win_pipe_d;
    logic [ROM_LAT-1:0]       von_pipe_q, von_pipe_d;
    logic                     font_bit;

    assign dx       = pixel_x - 10'(X0);
    assign dy       = pixel_y - 10'(Y0);
    assign bit_sel  = 3'(dx >> SCALE_LOG2);
    assign in_win   = (dx <= 10'(X1 - X0)) && (dy <= 10'(Y1 - Y0));
    assign rom_addr = {2'(dy >> (4 + SCALE_LOG2)),
                       5'(dx >> (3 + SCALE_LOG2)),
                       4'(dy >> SCALE_LOG2)};

`ifdef TEXT_OVERLAY_BLINK_EN
    logic phase_q, phase_d;
    assign vis = phase_q;
`else
    assign vis = 1'b1;
`endif

    // Shift the per-pixel flags one stage per clock.
    always_comb begin
        bit_pipe_d    = bit_pipe_q;
        win_pipe_d    = win_pipe_q;
        von_pipe_d    = von_pipe_q;
        bit_pipe_d[0] = bit_sel;
        win_pipe_d[0] = in_win;
        von_pipe_d[0] = video_on;
        for (int i = 1; i < ROM_LAT; i++) begin
            bit_pipe_d[i] = bit_pipe_q[i-1];
            win_pipe_d[i] = win_pipe_q[i-1];
            von_pipe_d[i] = von_pipe_q[i-1];
        end
    end

    assign font_bit = rom_data[3'd7 - bit_pipe_q[ROM_LAT-1]];

    // Final pixel mux: colour only for lit glyph pixels while shown.
    always_comb begin
        rgb_d = '0;
        if (von_pipe_q[ROM_LAT-1] && win_pipe_q[ROM_LAT-1] && font_bit && vis
            && (state_q == SHOW)) begin
            rgb_d = colour_q;
        end
    end

    // Show/hide FSM and colour sequencer; clear beats start.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        colour_d    = colour_q;
`ifdef TEXT_OVERLAY_BLINK_EN
        phase_d     = phase_q;
`endif
        colour_step = colour_q + RGB_W'(1);
        if (colour_step == '0) begin
            colour_step = RGB_W'(1);
        end

        if ((state_q == SHOW) && !freeze) begin
            if (count_q == CNT_LAST) begin
                count_d  = '0;
                colour_d = colour_step;
`ifdef TEXT_OVERLAY_BLINK_EN
                phase_d  = ~phase_q;
`endif
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end

        if (clear) begin
            state_d = HIDDEN;
        end else if (start) begin
            state_d  = SHOW;
            count_d  = '0;
            colour_d = RGB_W'(1);
`ifdef TEXT_OVERLAY_BLINK_EN
            phase_d  = 1'b1;
`endif
        end
    end

    // State, colour and pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HIDDEN;
            count_q    <= '0;
            colour_q   <= RGB_W'(1);
            rgb_q      <= '0;
            bit_pipe_q <= '0;
            win_pipe_q <= '0;
            von_pipe_q <= '0;
`ifdef TEXT_OVERLAY_BLINK_EN
            phase_q    <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            colour_q   <= colour_d;
            rgb_q      <= rgb_d;
            bit_pipe_q <= bit_pipe_d;
            win_pipe_q <= win_pipe_d;
            von_pipe_q <= von_pipe_d;
`ifdef TEXT_OVERLAY_BLINK_EN
            phase_q    <= phase_d;
`endif
        end
    end

    assign rgb_out = rgb_q;
    assign active  = (state_q == SHOW);

endmodule

// File: tb/tb_text_overlay_screen.sv
// Directed bench for text_overlay_screen (TICK_DIV=4, ROM_LAT=1).
// A one-cycle registered ROM model returns 8'hFF everywhere, or 8'h80 at
// address 0 and 8'h00 elsewhere, selected by rom_ff.
module tb_text_overlay_screen;

    logic        clk = 1'b0;
    logic        reset;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        start;
    logic        clear;
    logic        freeze;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic [2:0]  rgb_out;
    logic        active;
    logic        rom_ff;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic       vo;
        logic       ff;
        logic [2:0] exp_rgb;
    } vec_t;

    vec_t vecs [12];

    text_overlay_screen #(
        .RGB_W(3), .TICK_DIV(4), .X0(0), .X1(639), .Y0(128), .Y1(383),
        .SCALE_LOG2(2), .ROM_LAT(1)
    ) dut (
        .clk(clk), .reset(reset), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .start(start), .clear(clear), .freeze(freeze),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .rgb_out(rgb_out), .active(active)
    );

    always #5 clk = ~clk;

    // Synchronous text ROM, one cycle latency.
    always @(posedge clk) begin
        rom_data <= rom_ff ? 8'hFF : ((rom_addr == 11'd0) ? 8'h80 : 8'h00);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Expected colour p clocks after the first output of a fresh start
    // (4 clocks per colour, 1..7 then back to 1).
    function automatic logic [2:0] exp_rgb(input int p);
        int k;
        k = p / 4;
`ifdef TEXT_OVERLAY_BLINK_EN
        if ((k % 2) == 1) return 3'd0;
`endif
        return 3'((k % 7) + 1);
    endfunction

    // Start pulse; returns at the first cycle where the restarted colour shows.
    task automatic restart();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    initial begin
        vecs[0]  = '{10'd0,   10'd128, 1'b1, 1'b0, 3'd1};
        vecs[1]  = '{10'd4,   10'd128, 1'b1, 1'b0, 3'd0};
        vecs[2]  = '{10'd3,   10'd128, 1'b1, 1'b0, 3'd1};
        vecs[3]  = '{10'd0,   10'd131, 1'b1, 1'b0, 3'd1};
        vecs[4]  = '{10'd0,   10'd132, 1'b1, 1'b0, 3'd0};
        vecs[5]  = '{10'd32,  10'd128, 1'b1, 1'b0, 3'd0};
        vecs[6]  = '{10'd0,   10'd127, 1'b1, 1'b1, 3'd0};
        vecs[7]  = '{10'd0,   10'd384, 1'b1, 1'b1, 3'd0};
        vecs[8]  = '{10'd100, 10'd200, 1'b0, 1'b1, 3'd0};
        vecs[9]  = '{10'd639, 10'd383, 1'b1, 1'b1, 3'd1};
        vecs[10] = '{10'd640, 10'd200, 1'b1, 1'b1, 3'd0};
        vecs[11] = '{10'd320, 10'd256, 1'b1, 1'b1, 3'd1};

        reset    = 1'b1;
        video_on = 1'b1;
        pixel_x  = 10'd0;
        pixel_y  = 10'd128;
        rom_ff   = 1'b1;
        start    = 1'b0;
        clear    = 1'b0;
        freeze   = 1'b0;

        // Reset: output dark and FSM hidden, also after release.
        step();
        step();
        check("reset_rgb", 32'(rgb_out), 32'd0);
        check("reset_active", 32'(active), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hidden_rgb", 32'(rgb_out), 32'd0);
            check("hidden_active", 32'(active), 32'd0);
        end

        // Show with colour frozen at 1.
        freeze = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        check("start_active", 32'(active), 32'd1);
        step();
        check("start_rgb", 32'(rgb_out), 32'd1);

        // Address, glyph bit and window vectors.
        foreach (vecs[i]) begin
            pixel_x  = vecs[i].px;
            pixel_y  = vecs[i].py;
            video_on = vecs[i].vo;
            rom_ff   = vecs[i].ff;
            step();
            step();
            $display("vec %0d: x=%0d y=%0d vo=%0b ff=%0b rgb=%0d", i,
                     vecs[i].px, vecs[i].py, vecs[i].vo, vecs[i].ff, rgb_out);
            check($sformatf("vec%0d_rgb", i), 32'(rgb_out), 32'(vecs[i].exp_rgb));
        end

        // Colour cycling through the wrap, with a 10-clock freeze in period 7.
        pixel_x  = 10'd0;
        pixel_y  = 10'd128;
        video_on = 1'b1;
        rom_ff   = 1'b1;
        freeze   = 1'b0;
        restart();
        for (int p = 0; p < 34; p++) begin
            check($sformatf("cycle_p%0d", p), 32'(rgb_out), 32'(exp_rgb(p)));
            if (p == 29) begin
                freeze = 1'b1;
                for (int f = 0; f < 10; f++) begin
                    step();
                    check($sformatf("freeze_%0d", f), 32'(rgb_out), 32'(exp_rgb(29)));
                end
                freeze = 1'b0;
            end
            step();
        end

        // Restart while colour is 5: back to colour 1 with a fresh count.
        restart();
        for (int p = 0; p < 18; p++) begin
            step();
        end
        check("pre_restart_col5", 32'(rgb_out), 32'(exp_rgb(18)));
        restart();
        for (int p = 0; p < 5; p++) begin
            check($sformatf("restart_p%0d", p), 32'(rgb_out), 32'(exp_rgb(p)));
            step();
        end

        // Clear while shown.
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_active", 32'(active), 32'd0);
        step();
        check("clear_rgb", 32'(rgb_out), 32'd0);
        step();
        check("clear_rgb_hold", 32'(rgb_out), 32'd0);

        // start and clear together from HIDDEN: clear wins.
        start = 1'b1;
        clear = 1'b1;
        step();
        start = 1'b0;
        clear = 1'b0;
        check("sc_hidden_active", 32'(active), 32'd0);
        step();
        check("sc_hidden_rgb", 32'(rgb_out), 32'd0);

        // start and clear together from SHOW: clear wins.
        restart();
        check("reshow_rgb", 32'(rgb_out), 32'd1);
        check("reshow_active", 32'(active), 32'd1);
        start = 1'b1;
        clear = 1'b1;
        step();
        start = 1'b0;
        clear = 1'b0;
        check("sc_show_active", 32'(active), 32'd0);
        step();
        check("sc_show_rgb", 32'(rgb_out), 32'd0);

        // Reset in the middle of lit text.
        restart();
        check("pre_reset_rgb", 32'(rgb_out), 32'd1);
        reset = 1'b1;
        step();
        check("midreset_rgb", 32'(rgb_out), 32'd0);
        check("midreset_active", 32'(active), 32'd0);
        reset = 1'b0;
        step();
        check("post_reset_rgb", 32'(rgb_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
